// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1-to-8 demux dispatcher.
package demux_pkg;
    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic {IDLE, XFER} dispatch_state_t;
endpackage

// File: rtl/demux_dispatch_1x8_rr_pick8.sv
// Rotating-priority picker: first set mask bit searching ptr+1 .. ptr+8 (mod 8).
module rr_pick8
    import demux_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] sel,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset down so the nearest eligible channel wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = ptr + SEL_W'(k);
            if (mask[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_dispatch_1x8.sv
// Round-robin burst scheduler for a 1-to-8 demux: one valid/ready input,
// eight one-hot output channels sharing a single registered data beat.
module demux_dispatch_1x8
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en_mask,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [SEL_W-1:0] out_sel,
    output logic [NCH-1:0]   out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic [NCH-1:0]   out_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    dispatch_state_t  state, state_nxt;
    logic             hold_v;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [SEL_W-1:0] pick_sel;
    logic             pick_any;
    logic             retire, accept, leave;

    rr_pick8 u_pick (
        .mask (en_mask),
        .ptr  (ptr),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        retire    = 1'b0;
        accept    = 1'b0;
        leave     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && pick_any)
                    state_nxt = XFER;
            end
            XFER: begin
                retire   = hold_v & out_ready[out_sel];
                in_ready = en_mask[out_sel] & (beat_cnt < BURST_C) & (!hold_v | retire);
                accept   = in_valid & in_ready;
                // Release only once the register drains, so out_sel stays put under a held beat.
                leave    = (!hold_v | retire) & !accept &
                           ((beat_cnt == BURST_C) | !in_valid | !en_mask[out_sel]);
                if (leave)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_v   <= 1'b0;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '1;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == XFER) begin
                out_sel  <= pick_sel;
                beat_cnt <= '0;
            end
            if (accept) begin
                out_data <= in_data;
                hold_v   <= 1'b1;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end else if (retire) begin
                hold_v <= 1'b0;
            end
            if (leave)
                ptr <= out_sel;
        end
    end

    always_comb begin
        out_valid = '0;
        if (hold_v)
            out_valid[out_sel] = 1'b1;
    end

    assign busy = (state == XFER);

endmodule

// File: tb/tb_demux_dispatch_1x8.sv
// Scoreboard bench for demux_dispatch_1x8: directed scenarios plus random traffic.
module tb_demux_dispatch_1x8;

    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       en_mask = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [2:0]       out_sel;
    logic [7:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_ready = '0;
    logic             busy;

    demux_dispatch_1x8 #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_mask   (en_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       ch;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t sb[$];
    int    dch[256];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: grant owner, pointer, beats in this grant, register occupancy.
    int m_busy = 0, m_hold = 0, m_sel = 0, m_ptr = 7, m_cnt = 0;
    int exp_ov;
    bit m_ret, m_rdy, m_acc, found;
    beat_t mon_e;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_hold = 0; m_sel = 0; m_ptr = 7; m_cnt = 0;
            sb.delete();
        end else begin
            exp_ov = m_hold ? (1 << m_sel) : 0;
            check("out_valid", int'(out_valid), exp_ov);
            check("busy", int'(busy), m_busy);
            if (m_busy == 0) begin
                check("in_ready_idle", int'(in_ready), 0);
                if (in_valid && en_mask != 0) begin
                    found = 1'b0;
                    for (int k = 1; k <= 8; k++)
                        if (!found && en_mask[(m_ptr + k) % 8]) begin
                            m_sel = (m_ptr + k) % 8;
                            found = 1'b1;
                        end
                    m_cnt  = 0;
                    m_busy = 1;
                end
            end else begin
                check("out_sel", int'(out_sel), m_sel);
                m_ret = (m_hold != 0) && out_ready[m_sel];
                m_rdy = en_mask[m_sel] && (m_cnt < BURST) && ((m_hold == 0) || m_ret);
                m_acc = m_rdy && in_valid;
                check("in_ready", int'(in_ready), int'(m_rdy));
                if (m_acc) begin
                    sb.push_back({3'(m_sel), in_data});
                    m_hold = 1;
                    m_cnt++;
                end else begin
                    if (m_ret) m_hold = 0;
                    if (m_hold == 0 && (m_cnt == BURST || !in_valid || !en_mask[m_sel])) begin
                        m_busy = 0;
                        m_ptr  = m_sel;
                    end
                end
            end
        end
    end

    // Monitor: every retiring beat must match the oldest accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 8; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL spurious_retire: ch %0d data %0h with nothing expected", i, out_data);
                    end else begin
                        mon_e = sb.pop_front();
                        check("ret_ch", i, int'(mon_e.ch));
                        check("ret_data", int'(out_data), int'(mon_e.data));
                        dch[out_data] = i;
                    end
                end
            end
        end
    end

    task automatic tick(output bit hs);
        @(negedge clk);
        hs = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        bit hs;
        repeat (n) tick(hs);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input int first, input int n, input int max_cyc);
        bit hs;
        int cnt, cyc;
        cnt = 0; cyc = 0;
        in_valid = 1'b1;
        in_data  = WIDTH'(first);
        while (cnt < n && cyc < max_cyc) begin
            tick(hs);
            cyc++;
            if (hs) begin
                cnt++;
                in_data = WIDTH'(first + cnt);
            end
        end
        in_valid = 1'b0;
        check("send_timeout", cnt, n);
    endtask

    initial begin
        bit hs;
        int cnt, cyc;
        for (int i = 0; i < 256; i++) dch[i] = -1;

        // Reset state
        @(posedge clk); #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_sel", int'(out_sel), 0);
        check("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;

        // 9 beats across three grants
        en_mask = 8'hFF; out_ready = 8'hFF;
        send(8'h01, 9, 100);
        drain(10);
        for (int i = 1; i <= 9; i++) check("t1_ch", dch[i], (i - 1) / 4);

        // Two enabled channels, pointer wraps 7 -> 0
        do_reset();
        en_mask = 8'h81;
        send(8'h20, 12, 100);
        drain(10);
        for (int i = 0; i < 12; i++) check("t2_ch", dch[8'h20 + i], ((i / 4) % 2) ? 7 : 0);

        // Stalled consumer on ch3
        do_reset();
        en_mask = 8'h08; out_ready = 8'hF7;
        in_valid = 1'b1; in_data = 8'h30;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 20) begin tick(hs); cyc++; end
        check("t3_first_accept", int'(hs), 1);
        in_data = 8'h31;
        repeat (5) begin
            @(negedge clk);
            check("t3_in_ready", int'(in_ready), 0);
            check("t3_out_data", int'(out_data), 8'h30);
            check("t3_out_sel", int'(out_sel), 3);
            @(posedge clk); #1;
        end
        out_ready = 8'hFF;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 20) begin tick(hs); cyc++; end
        in_valid = 1'b0;
        drain(5);
        check("t3_ch30", dch[8'h30], 3);
        check("t3_ch31", dch[8'h31], 3);

        // Disable ch2 mid-burst
        do_reset();
        en_mask = 8'h0C; out_ready = 8'hFF;
        in_valid = 1'b1; in_data = 8'h40;
        cnt = 0; cyc = 0;
        while (cnt < 3 && cyc < 50) begin
            tick(hs); cyc++;
            if (hs) begin
                cnt++;
                in_data = WIDTH'(8'h40 + cnt);
                if (cnt == 2) en_mask = 8'h08;
            end
        end
        in_valid = 1'b0;
        check("t4_beats", cnt, 3);
        drain(6);
        check("t4_ch40", dch[8'h40], 2);
        check("t4_ch41", dch[8'h41], 2);
        check("t4_ch42", dch[8'h42], 3);

        // No channel enabled
        do_reset();
        en_mask = 8'h00; in_valid = 1'b1; in_data = 8'h50;
        repeat (10) begin
            @(negedge clk);
            check("t5_in_ready", int'(in_ready), 0);
            check("t5_out_valid", int'(out_valid), 0);
            check("t5_busy", int'(busy), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // Async reset with a held beat on ch5
        do_reset();
        en_mask = 8'h20; out_ready = 8'h00;
        in_valid = 1'b1; in_data = 8'h60;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 20) begin tick(hs); cyc++; end
        in_valid = 1'b0;
        tick(hs);
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_in_ready", int'(in_ready), 0);
        check("t6_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en_mask = 8'hFF; out_ready = 8'hFF;
        send(8'h61, 1, 20);
        drain(5);
        check("t6_first_grant", dch[8'h61], 0);
        check("t6_dropped_beat", dch[8'h60], -1);

        // Random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c % 25 == 0) en_mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = 8'($urandom) | 8'($urandom);
            tick(hs);
        end
        in_valid = 1'b0; out_ready = 8'hFF;
        drain(20);
        check("final_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
